// File: rtl/pipe_stage_reg_pkg.sv
`default_nettype none
// ============================================================================
// pipe_stage_reg_pkg
// Shared widths, occupancy encoding and per-stage control-bundle field offsets.
// Rev 1.0
// ============================================================================
package pipe_stage_reg_pkg;

   localparam int PIPE_DATA_W_DEFAULT = 32;
   localparam int PIPE_CTRL_W_DEFAULT = 8;

   typedef enum logic [1:0] {
      OCC_EMPTY = 2'd0,
      OCC_ONE   = 2'd1,
      OCC_FULL  = 2'd2
   } occ_t;

   // Control-bundle bit positions used by the stage wrappers when packing/unpacking
   localparam int ID_EX_REG_WE_BIT   = 0;
   localparam int ID_EX_MEM_RD_BIT   = 1;
   localparam int ID_EX_MEM_WR_BIT   = 2;
   localparam int ID_EX_ALU_SRC_BIT  = 3;
   localparam int ID_EX_ALU_OP_LSB   = 4;
   localparam int ID_EX_ALU_OP_W     = 4;

   localparam int EX_M_REG_WE_BIT    = 0;
   localparam int EX_M_MEM_RD_BIT    = 1;
   localparam int EX_M_MEM_WR_BIT    = 2;
   localparam int EX_M_WB_SEL_LSB    = 3;
   localparam int EX_M_WB_SEL_W      = 2;

   localparam int M_WB_REG_WE_BIT    = 0;
   localparam int M_WB_WB_SEL_LSB    = 1;
   localparam int M_WB_WB_SEL_W      = 2;

endpackage
`default_nettype wire

// File: rtl/pipe_stage_reg_slot.sv
`default_nettype none
// ============================================================================
// pipe_stage_reg_slot
// One storage entry: valid flag, payload and control bundle with load/clear.
// Rev 1.0
// ============================================================================
module pipe_stage_reg_slot #(
   parameter int DATA_W = 32,
   parameter int CTRL_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic              clear,
   input  logic              zero_ctrl,
   input  logic [DATA_W-1:0] d_data,
   input  logic [CTRL_W-1:0] d_ctrl,
   output logic              valid,
   output logic [DATA_W-1:0] data,
   output logic [CTRL_W-1:0] ctrl
);

   logic              r_valid;
   logic [DATA_W-1:0] r_data;
   logic [CTRL_W-1:0] r_ctrl;

   // Clear wins over load; data is left stale on clear since it is a don't-care.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_valid <= 1'b0;
         r_data  <= '0;
         r_ctrl  <= '0;
      end else if (clear) begin
         r_valid <= 1'b0;
         r_ctrl  <= '0;
      end else if (load) begin
         r_valid <= 1'b1;
         r_data  <= d_data;
         r_ctrl  <= zero_ctrl ? '0 : d_ctrl;
      end
   end

   assign valid = r_valid;
   assign data  = r_data;
   assign ctrl  = r_ctrl;

endmodule
`default_nettype wire

// File: rtl/pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// pipe_stage_reg
// Elastic valid/ready pipeline stage with optional 2-entry skid, flush and bubble.
// Rev 1.0
// ============================================================================
module pipe_stage_reg
   import pipe_stage_reg_pkg::*;
#(
   parameter int DATA_W = PIPE_DATA_W_DEFAULT,
   parameter int CTRL_W = PIPE_CTRL_W_DEFAULT,
   parameter bit SKID   = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic [CTRL_W-1:0] in_ctrl,
   input  logic              bubble,
   input  logic              flush,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [1:0]        count
);

   occ_t              r_state;
   logic              w_push;
   logic              w_pop;
   logic              w_from_skid;
   logic              w_main_v;
   logic [DATA_W-1:0] w_main_data;
   logic [CTRL_W-1:0] w_main_ctrl;
   logic              w_main_load;
   logic              w_main_clear;
   logic              w_main_zero;
   logic [DATA_W-1:0] w_main_d_data;
   logic [CTRL_W-1:0] w_main_d_ctrl;
   logic              w_skid_v;
   logic [DATA_W-1:0] w_skid_data;
   logic [CTRL_W-1:0] w_skid_ctrl;
   logic              w_skid_load;
   logic              w_skid_clear;

   assign w_pop       = w_main_v & out_ready;
   assign w_push      = in_valid & in_ready & ~flush;
   assign w_from_skid = (r_state == OCC_FULL);

   // Main is refilled from the skid when draining a full stage, else from the input.
   assign w_main_load   = (w_from_skid & w_pop) |
                          (w_push & ((r_state == OCC_EMPTY) | w_pop));
   assign w_main_clear  = flush | (w_pop & ~w_push & ~w_from_skid);
   assign w_main_zero   = ~w_from_skid & bubble;
   assign w_main_d_data = w_from_skid ? w_skid_data : in_data;
   assign w_main_d_ctrl = w_from_skid ? w_skid_ctrl : in_ctrl;

   assign w_skid_load   = w_push & (r_state == OCC_ONE) & ~w_pop;
   assign w_skid_clear  = flush | (w_from_skid & w_pop);

   pipe_stage_reg_slot #(
      .DATA_W (DATA_W),
      .CTRL_W (CTRL_W)
   ) u_main (
      .clk       (clk),
      .rst       (rst),
      .load      (w_main_load),
      .clear     (w_main_clear),
      .zero_ctrl (w_main_zero),
      .d_data    (w_main_d_data),
      .d_ctrl    (w_main_d_ctrl),
      .valid     (w_main_v),
      .data      (w_main_data),
      .ctrl      (w_main_ctrl)
   );

   generate
      if (SKID) begin : g_skid
         pipe_stage_reg_slot #(
            .DATA_W (DATA_W),
            .CTRL_W (CTRL_W)
         ) u_skid (
            .clk       (clk),
            .rst       (rst),
            .load      (w_skid_load),
            .clear     (w_skid_clear),
            .zero_ctrl (bubble),
            .d_data    (in_data),
            .d_ctrl    (in_ctrl),
            .valid     (w_skid_v),
            .data      (w_skid_data),
            .ctrl      (w_skid_ctrl)
         );
         assign in_ready = ~w_skid_v;
      end else begin : g_no_skid
         assign w_skid_v    = 1'b0;
         assign w_skid_data = '0;
         assign w_skid_ctrl = '0;
         assign in_ready    = ~w_main_v | out_ready;
      end
   endgenerate

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= OCC_EMPTY;
      end else if (flush) begin
         r_state <= OCC_EMPTY;
      end else begin
         case (r_state)
            OCC_EMPTY: if (w_push) r_state <= OCC_ONE;
            OCC_ONE: begin
               if (w_push && !w_pop)      r_state <= OCC_FULL;
               else if (!w_push && w_pop) r_state <= OCC_EMPTY;
            end
            OCC_FULL:  if (w_pop) r_state <= OCC_ONE;
            default:   r_state <= OCC_EMPTY;
         endcase
      end
   end

   assign out_valid = w_main_v;
   assign out_data  = w_main_data;
   assign out_ctrl  = w_main_v ? w_main_ctrl : '0;
   assign count     = {1'b0, w_main_v} + {1'b0, w_skid_v};

   a_skid_implies_main: assert property (@(posedge clk) disable iff (rst)
      (w_skid_v |-> w_main_v));
   a_state_matches_main: assert property (@(posedge clk) disable iff (rst)
      ((r_state != OCC_EMPTY) == w_main_v));
   a_state_matches_skid: assert property (@(posedge clk) disable iff (rst)
      ((r_state == OCC_FULL) == w_skid_v));

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// tb_pipe_stage_reg
// Scoreboard bench driving a SKID=1 and a SKID=0 stage with a shared stimulus stream.
// Rev 1.0
// ============================================================================
module tb_pipe_stage_reg;

   typedef struct packed {
      logic [31:0] d;
      logic [7:0]  c;
   } ent_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic [31:0] in_data = '0;
   logic [7:0]  in_ctrl = '0;
   logic        bubble = 1'b0;
   logic        flush = 1'b0;
   logic        out_ready = 1'b0;

   logic        ov0, ov1, ir0, ir1;
   logic [31:0] od0, od1;
   logic [7:0]  oc0, oc1;
   logic [1:0]  cnt0, cnt1;

   ent_t        expq[2][$];
   int          n_tests = 0;
   int          n_fail  = 0;
   logic        mon_en  = 1'b0;

   always #5 clk = ~clk;

   pipe_stage_reg #(.DATA_W(32), .CTRL_W(8), .SKID(1'b0)) dut0 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir0), .in_data(in_data),
      .in_ctrl(in_ctrl), .bubble(bubble), .flush(flush), .out_valid(ov0),
      .out_ready(out_ready), .out_data(od0), .out_ctrl(oc0), .count(cnt0));

   pipe_stage_reg #(.DATA_W(32), .CTRL_W(8), .SKID(1'b1)) dut1 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir1), .in_data(in_data),
      .in_ctrl(in_ctrl), .bubble(bubble), .flush(flush), .out_valid(ov1),
      .out_ready(out_ready), .out_data(od1), .out_ctrl(oc1), .count(cnt1));

   task automatic chk(input string name, input int k, input logic [31:0] act,
                      input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s dut%0d: got %h, expected %h at %0t", name, k, act, exp, $time);
      end
   endtask

   // Reference: a FIFO of capacity 2 (SKID=1) or 1 with pass-through refill (SKID=0).
   task automatic mon_one(input int k, input logic v, input logic rdy,
                          input logic [31:0] d, input logic [7:0] c, input logic [1:0] n);
      int   sz;
      logic exp_rdy;
      ent_t h;
      sz      = expq[k].size();
      exp_rdy = (k == 1) ? (sz < 2) : (sz == 0 || out_ready);
      chk("out_valid", k, 32'(v), 32'(sz > 0));
      chk("count", k, 32'(n), 32'(sz));
      chk("in_ready", k, 32'(rdy), 32'(exp_rdy));
      if (sz > 0) begin
         h = expq[k][0];
         chk("out_data", k, d, h.d);
         chk("out_ctrl", k, 32'(c), 32'(h.c));
         if (out_ready) void'(expq[k].pop_front());
      end else begin
         chk("idle_ctrl", k, 32'(c), 32'd0);
      end
      if (flush) expq[k].delete();
   endtask

   initial begin
      forever begin
         @(negedge clk);
         #2;
         if (mon_en) begin
            mon_one(0, ov0, ir0, od0, oc0, cnt0);
            mon_one(1, ov1, ir1, od1, oc1, cnt1);
         end
      end
   end

   task automatic cycle(input logic v, input logic [31:0] d, input logic [7:0] c,
                        input logic b, input logic f, input logic r);
      logic acc[2];
      ent_t e;
      @(negedge clk);
      in_valid  = v;
      in_data   = d;
      in_ctrl   = c;
      bubble    = b;
      flush     = f;
      out_ready = r;
      acc[1] = v && !f && (expq[1].size() < 2);
      acc[0] = v && !f && (expq[0].size() == 0 || r);
      e.d = d;
      e.c = b ? 8'h00 : c;
      @(posedge clk);
      #1;
      for (int k = 0; k < 2; k++)
         if (acc[k]) expq[k].push_back(e);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(1'b0, 32'h0, 8'h0, 1'b0, 1'b0, 1'b1);
   endtask

   task automatic drop_all();
      cycle(1'b0, 32'h0, 8'h0, 1'b0, 1'b1, 1'b0);
   endtask

   task automatic reset_mid();
      @(negedge clk);
      in_valid  = 1'b0;
      out_ready = 1'b0;
      bubble    = 1'b0;
      flush     = 1'b0;
      #1 chk("pre_rst_count", 1, 32'(cnt1), 32'd2);
      #2 rst = 1'b1;
      #1;
      chk("rst_out_valid", 1, 32'(ov1), 32'd0);
      chk("rst_out_ctrl", 1, 32'(oc1), 32'd0);
      chk("rst_count", 1, 32'(cnt1), 32'd0);
      chk("rst_in_ready", 1, 32'(ir1), 32'd1);
      chk("rst_out_valid", 0, 32'(ov0), 32'd0);
      chk("rst_count", 0, 32'(cnt0), 32'd0);
      expq[0].delete();
      expq[1].delete();
      @(posedge clk);
      #2 rst = 1'b0;
   endtask

   initial begin
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("por_out_valid", 1, 32'(ov1), 32'd0);
      chk("por_out_ctrl", 1, 32'(oc1), 32'd0);
      chk("por_count", 1, 32'(cnt1), 32'd0);
      chk("por_in_ready", 1, 32'(ir1), 32'd1);
      chk("por_in_ready", 0, 32'(ir0), 32'd1);
      rst    = 1'b0;
      mon_en = 1'b1;

      // Streaming with the consumer always ready
      cycle(1'b1, 32'h11, 8'h01, 1'b0, 1'b0, 1'b1);
      cycle(1'b1, 32'h22, 8'h02, 1'b0, 1'b0, 1'b1);
      cycle(1'b1, 32'h33, 8'h03, 1'b0, 1'b0, 1'b1);
      idle(2);

      // Backpressure: third push must be refused by the full stage
      cycle(1'b1, 32'hA, 8'h0A, 1'b0, 1'b0, 1'b0);
      cycle(1'b1, 32'hB, 8'h0B, 1'b0, 1'b0, 1'b0);
      cycle(1'b1, 32'hC, 8'h0C, 1'b0, 1'b0, 1'b0);
      cycle(1'b0, 32'h0, 8'h00, 1'b0, 1'b0, 1'b0);
      idle(3);

      // Bubble keeps data, zeroes control
      cycle(1'b1, 32'h5, 8'hFF, 1'b1, 1'b0, 1'b1);
      idle(2);

      // Flush of a full stage together with a new input
      cycle(1'b1, 32'h1, 8'h11, 1'b0, 1'b0, 1'b0);
      cycle(1'b1, 32'h2, 8'h22, 1'b0, 1'b0, 1'b0);
      cycle(1'b1, 32'h99, 8'h99, 1'b0, 1'b1, 1'b0);
      idle(2);

      // SKID=0 simultaneous push and pop
      cycle(1'b1, 32'h71, 8'h71, 1'b0, 1'b0, 1'b0);
      cycle(1'b1, 32'h72, 8'h72, 1'b0, 1'b0, 1'b1);
      idle(2);

      // Reset with a full stage
      drop_all();
      cycle(1'b1, 32'hD1, 8'hD1, 1'b0, 1'b0, 1'b0);
      cycle(1'b1, 32'hD2, 8'hD2, 1'b0, 1'b0, 1'b0);
      reset_mid();
      cycle(1'b1, 32'hE1, 8'hE1, 1'b0, 1'b0, 1'b1);
      idle(2);

      // Random traffic
      for (int i = 0; i < 3000; i++) begin
         cycle(1'($urandom_range(0, 9) < 7), $urandom, 8'($urandom),
               1'($urandom_range(0, 9) < 2), 1'($urandom_range(0, 19) == 0),
               1'($urandom_range(0, 9) < 6));
      end
      idle(4);

      @(negedge clk);
      #3;
      mon_en = 1'b0;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
